iq_frame_grabber: RTL and testbench
===================================

Name: iq_frame_grabber

Overview:
- Parametrised successor of the single-channel grab_channels deserializer.
- Deserializes the time-multiplexed DDC result stream (I0,Q0,I1,Q1,…) for N_CH channels into parallel per-channel I/Q registers.
- Validates the frame length and optionally averages 2^L frames before publishing.
- Sits between the vvm_dsp DDC/CIC output (vvm_ddc_result_iq / _strobe) and the phase/magnitude post-processing and CSR readout.

Parameters:
DW, 21, width of one I or Q word (CORDIC output width), signed
N_CH, 4, number of channels per frame; frame = 2*N_CH words
AW, 8, accumulator guard bits; maximum averaging exponent

Ports:
sample_clk  in  1  sample clock; all logic on rising edge
sample_rst_n  in  1  asynchronous, active-low reset
stream_in  in  DW  signed serial word, valid while strobe_in=1
strobe_in  in  1  high for exactly 2*N_CH consecutive cycles per frame
avg_log2  in  4  averaging exponent L; 0 = no averaging; values >AW are clamped to AW
err_clr  in  1  one-cycle pulse; clears the sticky error flags
i_out  out  N_CH*DW  channel k I at bits [k*DW +: DW]
q_out  out  N_CH*DW  channel k Q at bits [k*DW +: DW]
strobe_out  out  1  one-cycle pulse when i_out/q_out update
err_short  out  1  sticky: frame ended with fewer than 2*N_CH words
err_long  out  1  sticky: frame had more than 2*N_CH words
frame_cnt  out  16  count of published results; wraps at 2^16

Behaviour:
- Reset (async assert, sync release): all outputs 0, word counter 0, staging buffer and accumulators 0, averaging count 0, FSM in IDLE.
- FSM states: IDLE, COLLECT, OVERRUN.
  - IDLE: strobe_in=1 stores word 0 into staging[0]; counter <= 1; go to COLLECT.
  - COLLECT: strobe_in=1 with counter < 2N stores staging[counter] and increments the counter.
  - COLLECT: strobe_in=1 with counter == 2N sets err_long; frame discarded; go to OVERRUN.
  - COLLECT: strobe_in=0 with counter == 2N means the frame is valid; commit (below); go to IDLE.
  - COLLECT: strobe_in=0 with counter < 2N sets err_short; frame discarded; go to IDLE.
  - OVERRUN: ignores words until strobe_in=0, then goes to IDLE. No commit.
- Staging index mapping: even index 2k is channel k I; odd index 2k+1 is channel k Q.
- Commit, L = min(avg_log2, AW) latched at the start of each averaging block:
  - All 2N accumulators (width DW+AW, signed) add their staging word in parallel; the block counter increments.
  - When the block counter reaches 2^L:
    - each output word = acc >>> L (arithmetic shift, truncation toward -inf), taking the low DW bits;
    - strobe_out = 1 on that same edge;
    - frame_cnt increments;
    - accumulators and block counter clear, and L is re-latched.
  - L=0 publishes every valid frame unchanged.
- Latency: strobe_out and the new outputs appear on the clock edge that samples the first strobe_in=0 after a valid frame, i.e. visible 1 cycle after the low cycle.
- strobe_out is high for exactly one cycle; i_out/q_out hold their values between publications.
- Discarded (errored) frames neither add to the accumulators nor advance the block counter. A partially accumulated block survives an error.
- A new frame may start in the cycle directly after the commit cycle (gap of a single low cycle is legal).
- err_clr: clears both flags on the next edge. If an error event occurs in the same cycle as err_clr, the error wins and its flag stays set.
- A change of avg_log2 mid-block takes effect only at the next block boundary.
- Reset asserted mid-frame or mid-block aborts all state immediately; no strobe_out is produced.
- frame_cnt wraps from 0xFFFF to 0 without a flag.

Test Plan:
1. N_CH=4, L=0; a frame of words 1,-1,2,-2,3,-3,4,-4 followed by 1 low cycle -> i_out lanes {1,2,3,4}, q_out lanes {-1,-2,-3,-4}; strobe_out one pulse 1 cycle after the low cycle; frame_cnt=1.
2. L=2; four valid frames with I0 = 5,6,7,9 (sum 27) -> exactly one strobe_out, after frame 4, with I0 = 27>>>2 = 6. Frames with I0=-5 ×4 -> I0=-5; sum -6 -> -2 (floor).
3. Frame with only 6 words -> err_short=1, no strobe_out, outputs unchanged. The next valid frame publishes normally.
4. Frame with 10 words -> err_long=1 and the frame is discarded. During an L=1 block (frame A valid, long frame, frame B valid) -> publish (A+B)>>>1.
5. Assert err_clr in the same cycle as a new short-frame error -> err_short stays 1. err_clr alone -> both flags 0 on the next cycle.
6. Assert sample_rst_n low after 3 words -> outputs, frame_cnt and flags become 0 asynchronously. The first full frame after release publishes correctly. avg_log2=12 behaves as L=8 (256 frames per strobe_out).

Source files
------------

// File: rtl/iq_frame_grabber.sv
// iq_frame_grabber: deserializes the interleaved I/Q result stream of N_CH
// channels into parallel per-channel registers, validates frame length and
// optionally averages 2^L valid frames before publishing the result.
module iq_frame_grabber #(
  parameter int DW   = 21,
  parameter int N_CH = 4,
  parameter int AW   = 8
) (
  input  logic                   sample_clk,
  input  logic                   sample_rst_n,
  input  logic signed [DW-1:0]   stream_in,
  input  logic                   strobe_in,
  input  logic [3:0]             avg_log2,
  input  logic                   err_clr,
  output logic [N_CH*DW-1:0]     i_out,
  output logic [N_CH*DW-1:0]     q_out,
  output logic                   strobe_out,
  output logic                   err_short,
  output logic                   err_long,
  output logic [15:0]            frame_cnt
);

  localparam int NW   = 2 * N_CH;
  localparam int CW   = $clog2(NW + 1);
  localparam int LW   = $clog2(AW + 1);
  localparam int BW   = AW + 1;
  localparam int ACCW = DW + AW;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OVERRUN
  } state_e;

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic signed [DW-1:0]     stage_q [NW];
  logic signed [ACCW-1:0]   acc_q   [NW];
  logic [BW-1:0]            blk_q;
  logic [LW-1:0]            l_q;
  logic [N_CH*DW-1:0]       i_q;
  logic [N_CH*DW-1:0]       q_q;
  logic                     strobe_q;
  logic                     err_short_q;
  logic                     err_long_q;
  logic [15:0]              frame_cnt_q;

  logic [LW-1:0]            l_req;
  logic [LW-1:0]            l_d;
  logic [BW-1:0]            blk_d;
  logic                     publish_d;
  logic                     full;
  logic signed [ACCW-1:0]   acc_d   [NW];
  logic [N_CH*DW-1:0]       i_d;
  logic [N_CH*DW-1:0]       q_d;

  // Commit datapath: clamped exponent, block progress and the averaged result.
  // The exponent in use is taken fresh only when a block is empty, so a change
  // of avg_log2 mid-block waits for the next block.
  always_comb begin
    if (32'(avg_log2) > 32'(AW)) l_req = LW'(AW);
    else                         l_req = LW'(avg_log2);
    l_d       = (blk_q == '0) ? l_req : l_q;
    blk_d     = blk_q + 1'b1;
    publish_d = (blk_d == (BW'(1) << l_d));
    full      = (cnt_q == CW'(NW));
    i_d       = '0;
    q_d       = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      acc_d[j] = acc_q[j] + {{AW{stage_q[j][DW-1]}}, stage_q[j]};
    end
    for (int unsigned k = 0; k < N_CH; k++) begin
      i_d[k*DW +: DW] = DW'(acc_d[2*k]     >>> l_d);
      q_d[k*DW +: DW] = DW'(acc_d[2*k + 1] >>> l_d);
    end
  end

  // Frame FSM, staging, accumulation, error flags and registered outputs.
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      l_q         <= '0;
      i_q         <= '0;
      q_q         <= '0;
      strobe_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
      for (int unsigned j = 0; j < NW; j++) begin
        stage_q[j] <= '0;
        acc_q[j]   <= '0;
      end
    end else begin
      strobe_q <= 1'b0;
      // Clear first; an error event later in this block overrides it.
      if (err_clr) begin
        err_short_q <= 1'b0;
        err_long_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (strobe_in) begin
            stage_q[0] <= stream_in;
            cnt_q      <= CW'(1);
            state_q    <= COLLECT;
          end
        end
        COLLECT: begin
          if (strobe_in) begin
            if (full) begin
              err_long_q <= 1'b1;
              state_q    <= OVERRUN;
            end else begin
              for (int unsigned j = 0; j < NW; j++) begin
                if (cnt_q == CW'(j)) stage_q[j] <= stream_in;
              end
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            state_q <= IDLE;
            if (full) begin
              l_q <= l_d;
              if (publish_d) begin
                i_q         <= i_d;
                q_q         <= q_d;
                strobe_q    <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 1'b1;
                blk_q       <= '0;
                for (int unsigned j = 0; j < NW; j++) acc_q[j] <= '0;
              end else begin
                blk_q <= blk_d;
                for (int unsigned j = 0; j < NW; j++) acc_q[j] <= acc_d[j];
              end
            end else begin
              err_short_q <= 1'b1;
            end
          end
        end
        OVERRUN: begin
          if (!strobe_in) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_out      = i_q;
  assign q_out      = q_q;
  assign strobe_out = strobe_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_iq_frame_grabber.sv
// Scoreboard bench for iq_frame_grabber: the stimulus side runs a frame-level
// reference model and queues expected publications; a monitor pops and
// compares on every strobe_out.
module tb_iq_frame_grabber;

  localparam int DW   = 21;
  localparam int N_CH = 4;
  localparam int AW   = 8;
  localparam int NW   = 2 * N_CH;

  logic                 sample_clk;
  logic                 sample_rst_n;
  logic signed [DW-1:0] stream_in;
  logic                 strobe_in;
  logic [3:0]           avg_log2;
  logic                 err_clr;
  logic [N_CH*DW-1:0]   i_out;
  logic [N_CH*DW-1:0]   q_out;
  logic                 strobe_out;
  logic                 err_short;
  logic                 err_long;
  logic [15:0]          frame_cnt;

  iq_frame_grabber #(.DW(DW), .N_CH(N_CH), .AW(AW)) dut (
    .sample_clk   (sample_clk),
    .sample_rst_n (sample_rst_n),
    .stream_in    (stream_in),
    .strobe_in    (strobe_in),
    .avg_log2     (avg_log2),
    .err_clr      (err_clr),
    .i_out        (i_out),
    .q_out        (q_out),
    .strobe_out   (strobe_out),
    .err_short    (err_short),
    .err_long     (err_long),
    .frame_cnt    (frame_cnt)
  );

  initial sample_clk = 1'b0;
  always #5 sample_clk = ~sample_clk;

  typedef struct {
    logic [N_CH*DW-1:0] i;
    logic [N_CH*DW-1:0] q;
    logic [15:0]        cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  // Reference model state (frame level)
  logic signed [DW-1:0] words [0:15];
  longint               m_sum [NW];
  int                   m_cnt;
  int                   m_L;
  logic [15:0]          m_fc;
  bit                   m_es;
  bit                   m_el;
  logic [N_CH*DW-1:0]   m_last_i;
  logic [N_CH*DW-1:0]   m_last_q;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // floor(s / 2^L), reduced to a DW-bit lane
  function automatic logic [DW-1:0] lane(input longint s, input int L);
    longint      d;
    longint      q;
    logic [63:0] v;
    d = longint'(1) << L;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    v = q;
    return v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] rword();
    logic [31:0] r;
    r = $urandom();
    if (r[31:29] == 3'd0) return {1'b1, {(DW-1){1'b0}}};
    if (r[31:29] == 3'd1) return {1'b0, {(DW-1){1'b1}}};
    return r[DW-1:0];
  endfunction

  task automatic set_word(input int idx, input int v);
    logic [31:0] t;
    t = v;
    words[idx] = t[DW-1:0];
  endtask

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_sum[k] = 0;
    m_cnt = 0;
    m_L   = 0;
    m_fc  = '0;
    m_es  = 1'b0;
    m_el  = 1'b0;
    m_last_i = '0;
    m_last_q = '0;
  endtask

  task automatic model_frame(input int n, input bit clr, output bit pub);
    exp_t e;
    pub = 1'b0;
    if (n > NW) m_el = 1'b1;
    if (clr) begin
      m_es = 1'b0;
      m_el = 1'b0;
    end
    if (n < NW) m_es = 1'b1;
    if (n == NW) begin
      if (m_cnt == 0) m_L = (int'(avg_log2) > AW) ? AW : int'(avg_log2);
      for (int k = 0; k < NW; k++) m_sum[k] += longint'(words[k]);
      m_cnt++;
      if (m_cnt == (1 << m_L)) begin
        e.i = '0;
        e.q = '0;
        for (int k = 0; k < N_CH; k++) begin
          e.i[k*DW +: DW] = lane(m_sum[2*k], m_L);
          e.q[k*DW +: DW] = lane(m_sum[2*k+1], m_L);
        end
        m_fc  = m_fc + 16'd1;
        e.cnt = m_fc;
        sb.push_back(e);
        m_last_i = e.i;
        m_last_q = e.q;
        for (int k = 0; k < NW; k++) m_sum[k] = 0;
        m_cnt = 0;
        pub   = 1'b1;
      end
    end
  endtask

  // Drive n words, one low cycle (optionally with err_clr), check latency and
  // flags, then idle for the rest of the gap.
  task automatic send_frame(input int n, input int gap, input bit clr);
    bit pub;
    for (int i = 0; i < n; i++) begin
      @(negedge sample_clk);
      strobe_in = 1'b1;
      stream_in = words[i];
    end
    @(negedge sample_clk);
    strobe_in = 1'b0;
    stream_in = rword();
    err_clr   = clr;
    model_frame(n, clr, pub);
    @(negedge sample_clk);
    err_clr = 1'b0;
    chk("strobe_latency", 128'(strobe_out), 128'(pub));
    chk("err_short", 128'(err_short), 128'(m_es));
    chk("err_long", 128'(err_long), 128'(m_el));
    for (int g = 1; g < gap; g++) @(negedge sample_clk);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) words[i] = rword();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_out"}, 128'(i_out), 128'(0));
    chk({tag, "_q_out"}, 128'(q_out), 128'(0));
    chk({tag, "_strobe"}, 128'(strobe_out), 128'(0));
    chk({tag, "_err_short"}, 128'(err_short), 128'(0));
    chk({tag, "_err_long"}, 128'(err_long), 128'(0));
    chk({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(0));
  endtask

  // Monitor: every publication must match the next queued expectation.
  always @(negedge sample_clk) begin
    if (sample_rst_n && strobe_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe_out=1 expected no publication (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("pub_i_out", 128'(i_out), 128'(mon_e.i));
        chk("pub_q_out", 128'(q_out), 128'(mon_e.q));
        chk("pub_frame_cnt", 128'(frame_cnt), 128'(mon_e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sample_rst_n = 1'b0;
    stream_in    = '0;
    strobe_in    = 1'b0;
    avg_log2     = 4'd0;
    err_clr      = 1'b0;
    model_reset();
    repeat (3) @(negedge sample_clk);
    chk_zero("reset");
    sample_rst_n = 1'b1;
    @(negedge sample_clk);

    // 1: L=0, pass-through
    for (int k = 0; k < N_CH; k++) begin
      set_word(2*k, k + 1);
      set_word(2*k + 1, -(k + 1));
    end
    send_frame(NW, 1, 1'b0);

    // 2: L=2 averaging, positive and negative floors
    avg_log2 = 4'd2;
    begin
      int i0a[4] = '{5, 6, 7, 9};
      int i0b[4] = '{-1, -2, -1, -2};
      for (int f = 0; f < 4; f++) begin
        rand_words();
        set_word(0, i0a[f]);
        send_frame(NW, 1, 1'b0);
      end
      for (int f = 0; f < 4; f++) begin
        rand_words();
        set_word(0, -5);
        send_frame(NW, 2, 1'b0);
      end
      for (int f = 0; f < 4; f++) begin
        rand_words();
        set_word(0, i0b[f]);
        send_frame(NW, 1, 1'b0);
      end
    end

    // 3: short frame, outputs hold; then a valid frame
    avg_log2 = 4'd0;
    rand_words();
    send_frame(NW - 2, 1, 1'b0);
    chk("short_hold_i", 128'(i_out), 128'(m_last_i));
    chk("short_hold_q", 128'(q_out), 128'(m_last_q));
    rand_words();
    send_frame(NW, 1, 1'b0);

    // 4: long frame discarded; partial L=1 block survives it
    rand_words();
    send_frame(NW + 2, 1, 1'b0);
    avg_log2 = 4'd1;
    rand_words();
    send_frame(NW, 1, 1'b0);
    rand_words();
    send_frame(NW + 1, 1, 1'b0);
    rand_words();
    send_frame(NW, 1, 1'b0);

    // 5: err_clr racing a short error, then err_clr alone
    rand_words();
    send_frame(3, 1, 1'b1);
    rand_words();
    send_frame(NW + 1, 1, 1'b0);
    @(negedge sample_clk);
    err_clr = 1'b1;
    @(negedge sample_clk);
    err_clr = 1'b0;
    m_es = 1'b0;
    m_el = 1'b0;
    chk("clr_err_short", 128'(err_short), 128'(0));
    chk("clr_err_long", 128'(err_long), 128'(0));

    // 6: asynchronous reset mid-frame, with flags set and a block in progress
    avg_log2 = 4'd2;
    rand_words();
    send_frame(NW + 1, 1, 1'b0);
    send_frame(NW, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sample_clk);
      strobe_in = 1'b1;
      stream_in = rword();
    end
    #2;
    sample_rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    strobe_in = 1'b0;
    model_reset();
    @(negedge sample_clk);
    sample_rst_n = 1'b1;
    avg_log2 = 4'd0;
    rand_words();
    send_frame(NW, 1, 1'b0);

    // avg_log2 above AW clamps to AW
    avg_log2 = 4'd12;
    for (int f = 0; f < (1 << AW); f++) begin
      rand_words();
      send_frame(NW, 1, 1'b0);
    end

    // Randomized mix of lengths, gaps, exponents and clears
    for (int f = 0; f < 300; f++) begin
      int kind;
      int n;
      bit clr;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      n = int'($urandom_range(1, NW - 1));
      else if (kind == 1) n = int'($urandom_range(NW + 1, NW + 3));
      else                n = NW;
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) avg_log2 = 4'($urandom_range(0, 3));
      rand_words();
      send_frame(n, int'($urandom_range(1, 3)), clr);
    end

    repeat (4) @(negedge sample_clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
